// File: rtl/fir_sample_source.sv
// fir_sample_source: AXI-Stream master that feeds signed samples from a
// host-loaded RAM into the FIR filter's sample input. It streams a block
// of num_samples beats once, or loops over the block until stop is requested.
module fir_sample_source #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_samples,
  input  logic                  loop_en,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sent_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  // pf_data_r is the synchronous RAM read register; it always holds the
  // sample at rd_ptr_r, i.e. the beat that follows the one on the bus.
  logic [DATA_WIDTH-1:0] pf_data_r;
  logic [ADDR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]      len_r;
  logic                  loop_r;
  logic                  stop_pending_r;

  logic                  hs_s;
  logic                  advance_s;
  logic [CNT_W-1:0]      ptr_inc_s;
  logic [ADDR_W-1:0]     ptr_next_s;
  logic                  last_idx_s;
  logic [ADDR_W-1:0]     rd_addr_s;
  logic                  start_ok_s;
  logic                  start_zero_s;
  logic                  wr_ok_s;
  logic [CNT_W-1:0]      len_clamp_s;
  logic                  end_pass_s;
  logic [15:0]           sent_inc_s;

  // Handshake detection, read-address selection and start/write arbitration
  always_comb begin
    hs_s         = (state_r == ST_STREAM) && m_axis_tvalid && m_axis_tready;
    advance_s    = (state_r == ST_FETCH) || hs_s;
    ptr_inc_s    = {1'b0, rd_ptr_r} + ONE_C;
    last_idx_s   = ({1'b0, rd_ptr_r} == (len_r - ONE_C));
    start_ok_s   = (state_r == ST_IDLE) && start && (num_samples != {CNT_W{1'b0}});
    start_zero_s = (state_r == ST_IDLE) && start && (num_samples == {CNT_W{1'b0}});
    // Any start seen in IDLE takes priority over a host write that cycle.
    wr_ok_s      = wr_en && (state_r == ST_IDLE) && !start;
    end_pass_s   = hs_s && m_axis_tlast && (!loop_r || stop_pending_r || stop);

    if (ptr_inc_s >= len_r) begin
      ptr_next_s = {ADDR_W{1'b0}};
    end else begin
      ptr_next_s = ptr_inc_s[ADDR_W-1:0];
    end

    if (num_samples > DEPTH_C) begin
      len_clamp_s = DEPTH_C;
    end else begin
      len_clamp_s = num_samples;
    end

    if (sent_count == 16'hFFFF) begin
      sent_inc_s = sent_count;
    end else begin
      sent_inc_s = sent_count + 16'd1;
    end

    // In IDLE the RAM reads address 0 so the first sample is already in the
    // read register when FETCH loads the output stage. Afterwards the read
    // register re-reads its own address until the bus beat is consumed.
    if (state_r == ST_IDLE) begin
      rd_addr_s = {ADDR_W{1'b0}};
    end else if (advance_s) begin
      rd_addr_s = ptr_next_s;
    end else begin
      rd_addr_s = rd_ptr_r;
    end
  end

  // Host write port into the sample RAM (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Stream controller: FSM, prefetch, registered AXI outputs and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      pf_data_r      <= {DATA_WIDTH{1'b0}};
      rd_ptr_r       <= {ADDR_W{1'b0}};
      len_r          <= {CNT_W{1'b0}};
      loop_r         <= 1'b0;
      stop_pending_r <= 1'b0;
      m_axis_tdata   <= {DATA_WIDTH{1'b0}};
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sent_count     <= 16'd0;
    end else begin
      pf_data_r <= mem_r[rd_addr_s];
      done      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          m_axis_tvalid  <= 1'b0;
          m_axis_tlast   <= 1'b0;
          busy           <= 1'b0;
          stop_pending_r <= 1'b0;
          if (start_ok_s) begin
            state_r    <= ST_FETCH;
            len_r      <= len_clamp_s;
            loop_r     <= loop_en;
            sent_count <= 16'd0;
            rd_ptr_r   <= {ADDR_W{1'b0}};
            busy       <= 1'b1;
          end else if (start_zero_s) begin
            done <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          m_axis_tdata  <= pf_data_r;
          m_axis_tlast  <= last_idx_s;
          m_axis_tvalid <= 1'b1;
          rd_ptr_r      <= ptr_next_s;
          state_r       <= ST_STREAM;
          if (stop) begin
            stop_pending_r <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (stop) begin
            stop_pending_r <= 1'b1;
          end
          if (hs_s) begin
            sent_count <= sent_inc_s;
            if (end_pass_s) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state_r       <= ST_DONE;
            end else begin
              // Wrap at the end of a looping pass happens through ptr_next_s,
              // so the next pass starts without a bubble.
              m_axis_tdata <= pf_data_r;
              m_axis_tlast <= last_idx_s;
              rd_ptr_r     <= ptr_next_s;
            end
          end
        end
        ST_DONE: begin
          stop_pending_r <= 1'b0;
          state_r        <= ST_IDLE;
        end
        default: begin
          m_axis_tvalid  <= 1'b0;
          m_axis_tlast   <= 1'b0;
          busy           <= 1'b0;
          stop_pending_r <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_source.sv
// tb_fir_sample_source: directed bench for the FIR sample source covering
// single pass, backpressure, looping with stop, empty/oversized blocks,
// mid-stream reset and RAM write gating.
module tb_fir_sample_source;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [AW:0]   num_samples;
  logic          loop_en;
  logic          stop;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic [15:0]   sent_count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];

  always #5 clk = ~clk;

  fir_sample_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start         (start),
    .num_samples   (num_samples),
    .loop_en       (loop_en),
    .stop          (stop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .sent_count    (sent_count)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int n, input int passes);
    exp_d.delete();
    exp_l.delete();
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        exp_d.push_back(16'(i + 1));
        exp_l.push_back(i == n - 1);
      end
    end
  endtask

  // Starts a stream and collects beats until done (bounded).
  // rmode 0: tready always 1; rmode 1: tready pattern 1,0,0,1,0,1 repeating.
  task automatic run_stream(input int nsamp, input bit lp, input int rmode,
                            input int stop_beat, input int wr_beat, input string tag);
    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int            pat[6];
    int            first_v, first_hs, last_hs, done_k;
    bit            stall, wrote;
    logic [DW-1:0] st_d;
    logic          st_l;
    pat      = '{1, 0, 0, 1, 0, 1};
    first_v  = -1;
    first_hs = -1;
    last_hs  = -1;
    done_k   = -1;
    stall    = 1'b0;
    wrote    = 1'b0;
    st_d     = '0;
    st_l     = 1'b0;
    start       = 1'b1;
    num_samples = nsamp[AW:0];
    loop_en     = lp;
    tick;
    start   = 1'b0;
    loop_en = 1'b0;
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      stop  = 1'b0;
      wr_en = 1'b0;
      if (k == 1) begin
        chk_val({tag, " busy after start"}, 32'(busy), 32'd1);
        chk_val({tag, " no early valid"}, 32'(m_axis_tvalid), 32'd0);
      end
      if (done) begin
        done_k = k;
      end
      if (stall) begin
        chk_val({tag, " stall valid"}, 32'(m_axis_tvalid), 32'd1);
        chk_val({tag, " stall data"}, 32'(m_axis_tdata), 32'(st_d));
        chk_val({tag, " stall last"}, 32'(m_axis_tlast), 32'(st_l));
      end
      if (m_axis_tvalid && first_v < 0) begin
        first_v = k;
      end
      m_axis_tready = (rmode == 0) ? 1'b1 : (pat[k % 6] != 0);
      if (m_axis_tvalid && stop_beat > 0 && got_d.size() == stop_beat - 1) begin
        stop = 1'b1;
      end
      if (wr_beat > 0 && !wrote && got_d.size() == wr_beat) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 16'h7FFF;
        wrote   = 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        if (first_hs < 0) begin
          first_hs = k;
        end
        last_hs = k;
        stall   = 1'b0;
      end else if (m_axis_tvalid) begin
        stall = 1'b1;
        st_d  = m_axis_tdata;
        st_l  = m_axis_tlast;
      end else begin
        stall = 1'b0;
      end
      if (done_k < 0) begin
        tick;
      end
    end
    stop          = 1'b0;
    wr_en         = 1'b0;
    m_axis_tready = 1'b0;
    chk_val({tag, " done within budget"}, 32'(done_k > 0), 32'd1);
    chk_val({tag, " first valid cycle"}, 32'(first_v), 32'd2);
    chk_val({tag, " beat count"}, 32'(got_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk_val($sformatf("%s data[%0d]", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
      chk_val($sformatf("%s last[%0d]", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
    end
    chk_val({tag, " done after last beat"}, 32'(done_k), 32'(last_hs + 1));
    chk_val({tag, " valid low at done"}, 32'(m_axis_tvalid), 32'd0);
    chk_val({tag, " busy low at done"}, 32'(busy), 32'd0);
    if (rmode == 0) begin
      chk_val({tag, " back-to-back"}, 32'(last_hs - first_hs), 32'(exp_d.size() - 1));
    end
    tick;
    chk_val({tag, " done one cycle"}, 32'(done), 32'd0);
    chk_val({tag, " sent_count"}, 32'(sent_count), 32'(exp_d.size()));
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs;
    reset         = 1'b1;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    start         = 1'b0;
    num_samples   = '0;
    loop_en       = 1'b0;
    stop          = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst tvalid", 32'(m_axis_tvalid), 32'd0);
    chk_val("rst tlast", 32'(m_axis_tlast), 32'd0);
    chk_val("rst tdata", 32'(m_axis_tdata), 32'd0);
    chk_val("rst busy", 32'(busy), 32'd0);
    chk_val("rst done", 32'(done), 32'd0);
    chk_val("rst sent_count", 32'(sent_count), 32'd0);
    reset = 1'b0;
    tick;

    // Load RAM[i] = i+1 for the whole array
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = i[AW-1:0];
      wr_data = 16'(i + 1);
      tick;
    end
    wr_en = 1'b0;
    tick;

    // Single pass, no backpressure
    set_exp(8, 1);
    run_stream(8, 1'b0, 0, 0, 0, "pass8");
    tick;

    // Single pass with tready pattern
    set_exp(8, 1);
    run_stream(8, 1'b0, 1, 0, 0, "stall8");
    tick;

    // Looping 4-sample block, stop at 6th beat
    set_exp(4, 2);
    run_stream(4, 1'b1, 0, 6, 0, "loop4");
    tick;

    // Empty block: no beats, done next cycle
    start       = 1'b1;
    num_samples = '0;
    tick;
    start = 1'b0;
    chk_val("zero done", 32'(done), 32'd1);
    chk_val("zero busy", 32'(busy), 32'd0);
    chk_val("zero tvalid", 32'(m_axis_tvalid), 32'd0);
    tick;
    chk_val("zero done clear", 32'(done), 32'd0);
    chk_val("zero tvalid later", 32'(m_axis_tvalid), 32'd0);
    chk_val("zero busy later", 32'(busy), 32'd0);
    tick;

    // Oversized block clamps to DEPTH
    set_exp(DEPTH, 1);
    run_stream(65, 1'b0, 0, 0, 0, "clamp65");
    tick;

    // Reset during the 3rd beat while stalled
    start       = 1'b1;
    num_samples = 7'd8;
    tick;
    start = 1'b0;
    hs    = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_axis_tvalid && hs == 2) begin
        break;
      end
      m_axis_tready = 1'b1;
      if (m_axis_tvalid) begin
        hs++;
      end
      tick;
    end
    m_axis_tready = 1'b0;
    chk_val("rstmid beat3 valid", 32'(m_axis_tvalid), 32'd1);
    chk_val("rstmid beat3 data", 32'(m_axis_tdata), 32'd3);
    tick;
    #2;
    reset = 1'b1;
    #1;
    chk_val("rstmid tvalid", 32'(m_axis_tvalid), 32'd0);
    chk_val("rstmid busy", 32'(busy), 32'd0);
    chk_val("rstmid sent_count", 32'(sent_count), 32'd0);
    #2;
    reset = 1'b0;
    tick;
    set_exp(8, 1);
    run_stream(8, 1'b0, 0, 0, 0, "restart");
    tick;

    // Write while busy has no effect on this or the next stream
    set_exp(8, 1);
    run_stream(8, 1'b0, 0, 0, 3, "busywr");
    tick;
    run_stream(8, 1'b0, 0, 0, 0, "afterwr");
    tick;

    // Write in IDLE takes effect
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 16'h7FFF;
    tick;
    wr_en = 1'b0;
    tick;
    set_exp(8, 1);
    exp_d[0] = 16'h7FFF;
    run_stream(8, 1'b0, 0, 0, 0, "idlewr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
